// File: rtl/dac_writer_pkg.sv
// Shared definitions for the serial DAC writer: FSM state encodings, the default
// serial clock divider and the frame geometry of an MCP4921-class DAC.
package dac_writer_pkg;

    typedef enum logic [2:0] {
        DAC_IDLE,
        DAC_SHIFT,
        DAC_CS_HOLD,
        DAC_LDAC,
        DAC_GAP
    } dac_state_e;

    localparam int DAC_CLK_DIV   = 1;
    localparam int DAC_FRAME_LEN = 16;
    localparam int DAC_FIELD_LEN = 12;

endpackage

// File: rtl/dac_tick_gen.sv
// Clock divider producing a one-cycle tick every CLK_DIV+1 clk cycles.
// A synchronous clear holds the divider at zero so the first tick lands a full period later.
module dac_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic          wrap;

    assign wrap   = (div_q == CW'(CLK_DIV));
    assign tick_o = wrap && !clear_i;

    always_comb begin
        div_d = div_q + CW'(1);
        if (clear_i || wrap) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/dac_writer.sv
// Serial DAC transmitter: accepts a sample over valid/ready, shifts out a 16-bit MSB-first
// SPI frame, then strobes LDAC and waits a short gap before accepting again.
module dac_writer
    import dac_writer_pkg::*;
#(
    parameter int DAC_WIDTH   = 12,
    parameter int CLK_DIV     = DAC_CLK_DIV,
    parameter int GAP_TICKS   = 2,
    parameter bit DAC_CHANNEL = 1'b0,
    parameter bit DAC_BUF     = 1'b0,
    parameter bit DAC_GAIN1X  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DAC_WIDTH-1:0] dac_value,
    input  logic                 dac_valid,
    input  logic                 dac_shdn_n,
    output logic                 dac_ready,
    output logic                 dac_clk,
    output logic                 dac_cs,
    output logic                 dac_sdi,
    output logic                 dac_ldac_n,
    output logic                 done
);

    localparam int GW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

    dac_state_e                 state_q, state_d;
    logic [DAC_FRAME_LEN-1:0]   frame_q, frame_d;
    logic [4:0]                 bitCnt_q, bitCnt_d;
    logic [GW-1:0]              gapCnt_q, gapCnt_d;
    logic                       ready_q, ready_d;
    logic                       clk_q, clk_d;
    logic                       cs_q, cs_d;
    logic                       sdi_q, sdi_d;
    logic                       ldac_q, ldac_d;
    logic                       done_q, done_d;
    logic                       tick;
    logic [DAC_FIELD_LEN-1:0]   justified;

    assign justified = DAC_FIELD_LEN'(dac_value) << (DAC_FIELD_LEN - DAC_WIDTH);

    dac_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q == DAC_IDLE),
        .tick_o  (tick)
    );

    // Even bit-counter values mark rising dac_clk ticks; odd ones fall and advance the data.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bitCnt_d = bitCnt_q;
        gapCnt_d = gapCnt_q;
        ready_d  = ready_q;
        clk_d    = clk_q;
        cs_d     = cs_q;
        sdi_d    = sdi_q;
        ldac_d   = ldac_q;
        done_d   = 1'b0;
        case (state_q)
            DAC_IDLE: begin
                ready_d = 1'b1;
                if (dac_valid && ready_q) begin
                    frame_d  = {DAC_CHANNEL, DAC_BUF, DAC_GAIN1X, dac_shdn_n, justified};
                    ready_d  = 1'b0;
                    cs_d     = 1'b0;
                    sdi_d    = DAC_CHANNEL;
                    bitCnt_d = '0;
                    state_d  = DAC_SHIFT;
                end
            end
            DAC_SHIFT: begin
                if (tick) begin
                    bitCnt_d = bitCnt_q + 5'd1;
                    if (!bitCnt_q[0]) begin
                        clk_d = 1'b1;
                    end else begin
                        clk_d = 1'b0;
                        if (bitCnt_q == 5'd31) begin
                            state_d = DAC_CS_HOLD;
                        end else begin
                            sdi_d   = frame_q[DAC_FRAME_LEN-2];
                            frame_d = frame_q << 1;
                        end
                    end
                end
            end
            DAC_CS_HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    state_d = DAC_LDAC;
                end
            end
            DAC_LDAC: begin
                if (tick) begin
                    if (ldac_q) begin
                        ldac_d = 1'b0;
                    end else begin
                        ldac_d   = 1'b1;
                        done_d   = 1'b1;
                        gapCnt_d = '0;
                        if (GAP_TICKS == 0) begin
                            ready_d = 1'b1;
                            state_d = DAC_IDLE;
                        end else begin
                            state_d = DAC_GAP;
                        end
                    end
                end
            end
            DAC_GAP: begin
                if (tick) begin
                    if (gapCnt_q == GW'(GAP_TICKS - 1)) begin
                        ready_d = 1'b1;
                        state_d = DAC_IDLE;
                    end else begin
                        gapCnt_d = gapCnt_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = DAC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DAC_IDLE;
            frame_q  <= '0;
            bitCnt_q <= '0;
            gapCnt_q <= '0;
            ready_q  <= 1'b0;
            clk_q    <= 1'b0;
            cs_q     <= 1'b1;
            sdi_q    <= 1'b0;
            ldac_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            bitCnt_q <= bitCnt_d;
            gapCnt_q <= gapCnt_d;
            ready_q  <= ready_d;
            clk_q    <= clk_d;
            cs_q     <= cs_d;
            sdi_q    <= sdi_d;
            ldac_q   <= ldac_d;
            done_q   <= done_d;
        end
    end

    assign dac_ready  = ready_q;
    assign dac_clk    = clk_q;
    assign dac_cs     = cs_q;
    assign dac_sdi    = sdi_q;
    assign dac_ldac_n = ldac_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dac_writer.sv
// Directed bench for dac_writer: a default 12-bit instance plus an 8-bit instance, with
// SPI monitors that reassemble each frame from the bits present on dac_clk rises.
module tb_dac_writer;

    typedef struct {
        logic [11:0] value;
        logic        shdn;
        logic [15:0] frame;
    } vector_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [11:0] dacValue = '0;
    logic        dacValid = 1'b0;
    logic        dacShdnN = 1'b1;
    logic        dacReady, dacClk, dacCs, dacSdi, dacLdacN, dacDone;

    logic [7:0]  v8Value = '0;
    logic        v8Valid = 1'b0;
    logic        ready8, clk8, cs8, sdi8, ldac8, done8;

    int passCount = 0;
    int checkCount = 0;
    int doneCount = 0;

    logic [15:0] rxShift = '0;
    int          rxBits = 0;
    logic [15:0] frameQ[$];
    int          bitsQ[$];
    logic [15:0] rxShift8 = '0;
    logic [15:0] frameQ8[$];

    always #5 clk = ~clk;

    dac_writer dut (
        .clk        (clk),
        .rst_n      (rstN),
        .dac_value  (dacValue),
        .dac_valid  (dacValid),
        .dac_shdn_n (dacShdnN),
        .dac_ready  (dacReady),
        .dac_clk    (dacClk),
        .dac_cs     (dacCs),
        .dac_sdi    (dacSdi),
        .dac_ldac_n (dacLdacN),
        .done       (dacDone)
    );

    dac_writer #(.DAC_WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rstN),
        .dac_value  (v8Value),
        .dac_valid  (v8Valid),
        .dac_shdn_n (1'b1),
        .dac_ready  (ready8),
        .dac_clk    (clk8),
        .dac_cs     (cs8),
        .dac_sdi    (sdi8),
        .dac_ldac_n (ldac8),
        .done       (done8)
    );

    // A chip-select rise closes the frame, whether complete or cut short by reset.
    always @(posedge dacClk or posedge dacCs) begin
        if (dacCs) begin
            frameQ.push_back(rxShift);
            bitsQ.push_back(rxBits);
            rxBits <= 0;
        end else begin
            rxShift <= {rxShift[14:0], dacSdi};
            rxBits  <= rxBits + 1;
        end
    end

    always @(posedge clk8 or posedge cs8) begin
        if (cs8) begin
            frameQ8.push_back(rxShift8);
        end else begin
            rxShift8 <= {rxShift8[14:0], sdi8};
        end
    end

    always @(posedge clk) begin
        if (dacDone === 1'b1) begin
            doneCount <= doneCount + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents a sample, waits for ready, and returns #1 after the accept edge (e0).
    task automatic applyStimulus(input logic [11:0] value, input logic shdn, input bit keepValid);
        int waitCycles = 0;
        dacValue = value;
        dacShdnN = shdn;
        dacValid = 1'b1;
        while (dacReady !== 1'b1 && waitCycles < 300) begin
            tick();
            waitCycles++;
        end
        if (waitCycles >= 300) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        tick();
        if (!keepValid) begin
            dacValid = 1'b0;
        end
    endtask

    task automatic waitFrames(input int count);
        int waitCycles = 0;
        while (frameQ.size() < count && waitCycles < 500) begin
            tick();
            waitCycles++;
        end
        if (waitCycles >= 500) begin
            checkOutput("frame_timeout", frameQ.size(), count);
        end
    endtask

    initial begin
        vector_t vectors[5];
        int csRiseK, ldacFirstK, doneK, readyK, firstClkK, csLowCnt, ldacLowCnt;
        int doneStart, fallK, waitCycles;
        bit sawHigh, clkMoved;

        vectors[0] = '{value: 12'hA5C, shdn: 1'b1, frame: 16'h3A5C};
        vectors[1] = '{value: 12'h001, shdn: 1'b1, frame: 16'h3001};
        vectors[2] = '{value: 12'h800, shdn: 1'b1, frame: 16'h3800};
        vectors[3] = '{value: 12'hFFF, shdn: 1'b0, frame: 16'h2FFF};
        vectors[4] = '{value: 12'h000, shdn: 1'b1, frame: 16'h3000};

        // Reset values and release
        repeat (3) tick();
        checkOutput("reset_ready", dacReady, 0);
        checkOutput("reset_dac_clk", dacClk, 0);
        checkOutput("reset_cs", dacCs, 1);
        checkOutput("reset_sdi", dacSdi, 0);
        checkOutput("reset_ldac_n", dacLdacN, 1);
        checkOutput("reset_done", dacDone, 0);
        rstN = 1'b1;
        tick();
        checkOutput("ready_after_release", dacReady, 1);
        clkMoved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dacClk !== 1'b0) clkMoved = 1'b1;
        end
        checkOutput("idle_dac_clk_static", clkMoved, 0);
        frameQ.delete();
        bitsQ.delete();
        frameQ8.delete();

        // Full frame timing for 12'hA5C
        doneStart = doneCount;
        csRiseK = -1; ldacFirstK = -1; doneK = -1; readyK = -1; firstClkK = -1;
        csLowCnt = 0; ldacLowCnt = 0;
        applyStimulus(12'hA5C, 1'b1, 1'b0);
        checkOutput("ready_low_after_accept", dacReady, 0);
        checkOutput("sdi_msb_after_accept", dacSdi, 0);
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) tick();
            if (!dacCs) csLowCnt++;
            else if (csRiseK < 0) csRiseK = k;
            if (dacClk && firstClkK < 0) firstClkK = k;
            if (!dacLdacN) begin
                ldacLowCnt++;
                if (ldacFirstK < 0) ldacFirstK = k;
            end
            if (dacDone && doneK < 0) doneK = k;
            if (dacReady && readyK < 0) readyK = k;
        end
        checkOutput("first_dac_clk_rise", firstClkK, 2);
        checkOutput("cs_low_cycles", csLowCnt, 66);
        checkOutput("cs_rise_edge", csRiseK, 66);
        checkOutput("ldac_low_edge", ldacFirstK, 68);
        checkOutput("ldac_low_cycles", ldacLowCnt, 2);
        checkOutput("done_edge", doneK, 70);
        checkOutput("done_pulses", doneCount - doneStart, 1);
        checkOutput("ready_high_edge", readyK, 74);
        checkOutput("frame_count_a5c", frameQ.size(), 1);
        if (frameQ.size() > 0) begin
            checkOutput("frame_a5c", frameQ[0], 16'h3A5C);
            checkOutput("bits_a5c", bitsQ[0], 16);
        end
        frameQ.delete();
        bitsQ.delete();

        // Table of frames
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].value, vectors[i].shdn, 1'b0);
            waitFrames(1);
            if (frameQ.size() > 0) begin
                checkOutput($sformatf("frame_vec%0d", i), frameQ[0], vectors[i].frame);
            end
            frameQ.delete();
            bitsQ.delete();
        end

        // A new sample offered mid-frame is ignored
        applyStimulus(12'h5A5, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) begin
                dacValue = 12'hFFF;
                dacValid = 1'b1;
            end
        end
        dacValid = 1'b0;
        waitFrames(1);
        repeat (120) tick();
        checkOutput("ignored_frame_count", frameQ.size(), 1);
        if (frameQ.size() > 0) begin
            checkOutput("ignored_frame_bits", frameQ[0], 16'h35A5);
        end
        frameQ.delete();
        bitsQ.delete();

        // Back-to-back with valid held high
        applyStimulus(12'h001, 1'b1, 1'b1);
        dacValue = 12'h800;
        sawHigh = 1'b0;
        fallK = -1;
        for (int k = 1; k <= 200 && fallK < 0; k++) begin
            tick();
            if (dacCs) sawHigh = 1'b1;
            else if (sawHigh) fallK = k;
        end
        dacValid = 1'b0;
        checkOutput("back_to_back_accept_gap", fallK, 75);
        waitFrames(2);
        if (frameQ.size() >= 2) begin
            checkOutput("b2b_frame0", frameQ[0], 16'h3001);
            checkOutput("b2b_frame1", frameQ[1], 16'h3800);
        end
        repeat (20) tick();
        frameQ.delete();
        bitsQ.delete();

        // Reset in the middle of SHIFT
        doneStart = doneCount;
        applyStimulus(12'h5A5, 1'b1, 1'b0);
        repeat (19) tick();
        rstN = 1'b0;
        tick();
        checkOutput("midreset_cs", dacCs, 1);
        checkOutput("midreset_dac_clk", dacClk, 0);
        checkOutput("midreset_ldac_n", dacLdacN, 1);
        checkOutput("midreset_ready", dacReady, 0);
        rstN = 1'b1;
        repeat (100) tick();
        checkOutput("midreset_no_done", doneCount - doneStart, 0);
        checkOutput("midreset_partial_frames", bitsQ.size(), 1);
        if (bitsQ.size() > 0) begin
            checkOutput("midreset_partial_bits", bitsQ[0], 5);
        end
        frameQ.delete();
        bitsQ.delete();
        applyStimulus(12'h123, 1'b1, 1'b0);
        waitFrames(1);
        if (frameQ.size() > 0) begin
            checkOutput("post_reset_frame", frameQ[0], 16'h3123);
        end
        repeat (20) tick();
        checkOutput("post_reset_done", doneCount - doneStart, 1);

        // 8-bit instance: left-justified sample
        v8Value = 8'hC3;
        v8Valid = 1'b1;
        waitCycles = 0;
        while (ready8 !== 1'b1 && waitCycles < 300) begin
            tick();
            waitCycles++;
        end
        tick();
        v8Valid = 1'b0;
        waitCycles = 0;
        while (frameQ8.size() < 1 && waitCycles < 500) begin
            tick();
            waitCycles++;
        end
        checkOutput("w8_frame_count", frameQ8.size(), 1);
        if (frameQ8.size() > 0) begin
            checkOutput("w8_frame", frameQ8[0], 16'h3C30);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
